// File: rtl/rx_pad_stripper.sv
// rx_pad_stripper: removes Ethernet pad bytes from a 64-bit receive data path, one cycle of latency.
// Optional strip statistics (strip_cnt output) are built when RX_PAD_STRIP_STATS_EN is defined.

module rx_pad_lane #(
   parameter int LANE_IDX = 0,
   parameter int LANE_W   = 8
) (
   input  logic [LANE_W-1:0] din,
   input  logic              full,
   input  logic [2:0]        bits,
   output logic              keep,
   output logic [LANE_W-1:0] dout
);
   // A lane survives on a full word, or on the tail word when it lies below the true byte count.
   assign keep = full | (LANE_IDX < int'(bits));
   assign dout = keep ? din : '0;
endmodule

module rx_pad_stripper (
   input  logic        rxclk,
   input  logic        reset,
   input  logic [63:0] in_data,
   input  logic        in_valid,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic        len_strobe,
   input  logic        small_frame,
   input  logic [12:0] small_integer_cnt,
   input  logic [2:0]  small_bits_more,
   output logic [63:0] out_data,
   output logic        out_valid,
   output logic [7:0]  out_keep,
   output logic        out_eop,
   output logic        short_err
`ifdef RX_PAD_STRIP_STATS_EN
   ,
   output logic [15:0] strip_cnt
`endif
);
   localparam int NUM_LANES = 8;
   localparam int LANE_W    = 8;

   typedef enum logic [1:0] {IDLE, PASS, STRIP, DROP} state_t;

   state_t      state, nxt_state, act_state;
   logic [12:0] w, nxt_w, act_w;
   logic [12:0] cnt_q, act_cnt;
   logic [2:0]  bits_q, act_bits;
   logic        start, emit, full, eop_n, serr_n, last_full;

   logic [NUM_LANES-1:0]             lane_keep;
   logic [NUM_LANES-1:0][LANE_W-1:0] lane_data;

   // The sop word is decoded under the state it opens, with the freshly sampled length.
   always_comb begin
      start     = 1'b0;
      nxt_state = state;
      nxt_w     = w;
      act_state = state;
      act_w     = w;
      act_cnt   = cnt_q;
      act_bits  = bits_q;
      emit      = 1'b0;
      full      = 1'b0;
      eop_n     = 1'b0;
      serr_n    = 1'b0;
      last_full = 1'b0;
      if (in_valid) begin
         if (state == IDLE && in_sop) begin
            start     = 1'b1;
            act_state = (len_strobe && small_frame) ? STRIP : PASS;
            act_w     = '0;
            act_cnt   = small_integer_cnt;
            act_bits  = small_bits_more;
         end
         nxt_state = act_state;
         case (act_state)
            PASS: begin
               emit  = 1'b1;
               full  = 1'b1;
               eop_n = in_eop;
               if (in_eop) nxt_state = IDLE;
            end
            STRIP: begin
               emit      = 1'b1;
               nxt_w     = act_w + 13'd1;
               last_full = (act_cnt != '0) && (act_w == act_cnt - 13'd1) && (act_bits == 3'd0);
               if (act_w < act_cnt) begin
                  full = 1'b1;
                  if (last_full) begin
                     eop_n     = 1'b1;
                     nxt_state = in_eop ? IDLE : DROP;
                  end else if (in_eop) begin
                     eop_n     = 1'b1;
                     serr_n    = 1'b1;
                     nxt_state = IDLE;
                  end
               end else begin
                  // Tail word; with no true bytes at all this carries an empty keep.
                  eop_n     = 1'b1;
                  nxt_state = in_eop ? IDLE : DROP;
               end
            end
            DROP: if (in_eop) nxt_state = IDLE;
            default: ;
         endcase
         if (nxt_state == IDLE) nxt_w = '0;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      rx_pad_lane #(.LANE_IDX(i), .LANE_W(LANE_W)) u_lane (
         .din  (in_data[i*LANE_W +: LANE_W]),
         .full (full),
         .bits (act_bits),
         .keep (lane_keep[i]),
         .dout (lane_data[i])
      );
   end

   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         w         <= '0;
         cnt_q     <= '0;
         bits_q    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_keep  <= '0;
         out_eop   <= 1'b0;
         short_err <= 1'b0;
      end else begin
         state     <= nxt_state;
         w         <= nxt_w;
         if (start) begin
            cnt_q  <= small_integer_cnt;
            bits_q <= small_bits_more;
         end
         out_valid <= emit;
         out_keep  <= emit ? lane_keep : '0;
         out_eop   <= eop_n;
         short_err <= serr_n;
         if (emit) out_data <= lane_data;
      end
   end

`ifdef RX_PAD_STRIP_STATS_EN
   logic strip_eop;
   assign strip_eop = emit && eop_n && (act_state == STRIP);

   always_ff @(posedge rxclk or posedge reset) begin
      if (reset)                             strip_cnt <= '0;
      else if (strip_eop && strip_cnt != '1) strip_cnt <= strip_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_rx_pad_stripper.sv
// Directed + randomized bench for rx_pad_stripper; expected outputs come from a byte-count frame model.
module tb_rx_pad_stripper;
   logic        rxclk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
   logic        len_strobe = 1'b0, small_frame = 1'b0;
   logic [12:0] small_integer_cnt = '0;
   logic [2:0]  small_bits_more = '0;
   logic [63:0] out_data;
   logic        out_valid;
   logic [7:0]  out_keep;
   logic        out_eop;
   logic        short_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 rxclk = ~rxclk;

   rx_pad_stripper dut (
      .rxclk             (rxclk),
      .reset             (reset),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .in_sop            (in_sop),
      .in_eop            (in_eop),
      .len_strobe        (len_strobe),
      .small_frame       (small_frame),
      .small_integer_cnt (small_integer_cnt),
      .small_bits_more   (small_bits_more),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_keep          (out_keep),
      .out_eop           (out_eop),
      .short_err         (short_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] byte_mask(input logic [7:0] k);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   // Present one input cycle, then check the registered response one cycle later.
   task automatic word(input logic v, input logic sop, input logic eop, input logic [63:0] d,
                       input logic ls, input logic sf, input logic [12:0] c, input logic [2:0] b,
                       input logic ev, input logic [7:0] ek, input logic ee, input logic es,
                       input string tag);
      in_valid = v; in_sop = sop; in_eop = eop; in_data = d;
      len_strobe = ls; small_frame = sf; small_integer_cnt = c; small_bits_more = b;
      @(posedge rxclk);
      #1;
      check({tag, ".valid"}, 64'(out_valid), 64'(ev));
      if (ev) begin
         check({tag, ".keep"}, 64'(out_keep), 64'(ek));
         check({tag, ".eop"},  64'(out_eop),  64'(ee));
         check({tag, ".data"}, out_data, d & byte_mask(ek));
      end
      check({tag, ".short_err"}, 64'(short_err), 64'(es));
   endtask

   task automatic idle_cycle(input string tag);
      word(1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
           13'($urandom), 3'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, {tag, ".idle"});
   endtask

   // Frame model: true length in bytes decides which words survive and how much of the tail is kept.
   task automatic send_frame(input int n, input logic sf, input logic ls, input int cnt, input int bits,
                             input bit gaps, input string tag);
      int          tbytes, k, nb, ng;
      logic        strip, ev, ee, es, sop;
      logic [7:0]  ek;
      strip  = sf && ls;
      tbytes = cnt * 8 + bits;
      k      = (tbytes == 0) ? 1 : (tbytes + 7) / 8;
      for (int i = 0; i < n; i++) begin
         ng = gaps ? $urandom_range(0, 2) : 0;
         for (int g = 0; g < ng; g++) idle_cycle(tag);
         if (!strip) begin
            ev = 1'b1; ek = 8'hFF; ee = (i == n - 1); es = 1'b0;
         end else if (i >= k) begin
            ev = 1'b0; ek = 8'h00; ee = 1'b0; es = 1'b0;
         end else if (i == n - 1 && i < k - 1) begin
            ev = 1'b1; ek = 8'hFF; ee = 1'b1; es = 1'b1;
         end else begin
            nb = tbytes - 8 * i;
            if (nb > 8) nb = 8;
            ev = 1'b1; ek = 8'((1 << nb) - 1); ee = (i == k - 1); es = 1'b0;
         end
         sop = (i == 0) ? 1'b1 : (gaps && $urandom_range(0, 3) == 0);
         if (i == 0)
            word(1'b1, sop, (i == n - 1), {$urandom, $urandom}, ls, sf, 13'(cnt), 3'(bits),
                 ev, ek, ee, es, $sformatf("%s.w%0d", tag, i));
         else
            word(1'b1, sop, (i == n - 1), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                 13'($urandom), 3'($urandom), ev, ek, ee, es, $sformatf("%s.w%0d", tag, i));
      end
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.keep",  64'(out_keep),  64'd0);
      check("rst.eop",   64'(out_eop),   64'd0);
      check("rst.serr",  64'(short_err), 64'd0);
      check("rst.data",  out_data,       64'd0);
      @(posedge rxclk); @(posedge rxclk); #1 reset = 1'b0;

      send_frame(6, 1'b0, 1'b1, 1, 1, 1'b0, "pass6");
      send_frame(6, 1'b1, 1'b1, 2, 3, 1'b0, "strip_2_3");
      send_frame(6, 1'b1, 1'b1, 3, 0, 1'b0, "strip_3_0");
      send_frame(6, 1'b1, 1'b1, 0, 0, 1'b0, "strip_0_0");
      send_frame(3, 1'b1, 1'b1, 4, 2, 1'b0, "short_4_2");
      send_frame(2, 1'b0, 1'b0, 0, 0, 1'b0, "after_short");
      send_frame(4, 1'b1, 1'b0, 1, 0, 1'b0, "no_strobe");
      send_frame(1, 1'b0, 1'b1, 0, 0, 1'b0, "pass1");
      send_frame(1, 1'b1, 1'b1, 0, 5, 1'b0, "strip1_0_5");
      send_frame(1, 1'b1, 1'b1, 1, 0, 1'b0, "strip1_1_0");
      send_frame(5, 1'b1, 1'b1, 2, 7, 1'b1, "gapped");

      // Valid words outside a frame are not forwarded.
      for (int i = 0; i < 3; i++)
         word(1'b1, 1'b0, 1'($urandom), {$urandom, $urandom}, 1'b0, 1'b0, '0, '0,
              1'b0, 8'h00, 1'b0, 1'b0, "stray");

      // Reset lands on word 1 of a STRIP frame; its remaining words must vanish.
      word(1'b1, 1'b1, 1'b0, {$urandom, $urandom}, 1'b1, 1'b1, 13'd2, 3'd3,
           1'b1, 8'hFF, 1'b0, 1'b0, "mid.w0");
      in_sop = 1'b0; in_data = {$urandom, $urandom};
      #2 reset = 1'b1;
      #1;
      check("mid.rst.valid", 64'(out_valid), 64'd0);
      check("mid.rst.keep",  64'(out_keep),  64'd0);
      check("mid.rst.data",  out_data,       64'd0);
      @(posedge rxclk); #1 reset = 1'b0;
      check("mid.after.valid", 64'(out_valid), 64'd0);
      for (int i = 2; i < 6; i++)
         word(1'b1, 1'b0, (i == 5), {$urandom, $urandom}, 1'b1, 1'b1, 13'd2, 3'd3,
              1'b0, 8'h00, 1'b0, 1'b0, $sformatf("mid.w%0d", i));
      send_frame(6, 1'b0, 1'b0, 0, 0, 1'b0, "mid.pass");

      for (int f = 0; f < 40; f++)
         send_frame($urandom_range(1, 10), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    $urandom_range(0, 9), $urandom_range(0, 7), 1'($urandom), $sformatf("rnd%0d", f));
      idle_cycle("tail");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rx_pad_stripper.md
RX_PAD_STRIPPER -- requirements
Module: rx_pad_stripper

Interface
REQ-001 SHALL have ports: rxclk input 1: receive clock; all logic is on its rising edge.
REQ-002 SHALL have ports: reset input 1: asynchronous, active-high reset.
REQ-003 SHALL have ports: in_data input 64: data-field word; byte i sits in bits [8i+7:8i].
REQ-004 SHALL have ports: in_valid input 1: in_data is valid this cycle.
REQ-005 SHALL have ports: in_sop input 1: first data-field word of a frame; qualified by in_valid.
REQ-006 SHALL have ports: in_eop input 1: last data-field word of a frame (padding included); qualified by in_valid.
REQ-007 SHALL have ports: len_strobe input 1: length information is valid; sampled on the in_sop cycle.
REQ-008 SHALL have ports: small_frame input 1: data field is shorter than the 46-byte minimum and carries padding.
REQ-009 SHALL have ports: small_integer_cnt input 13: number of whole 64-bit words of true data.
REQ-010 SHALL have ports: small_bits_more input 3: number of true bytes in the final partial word.
REQ-011 SHALL have ports: out_data output 64: data word with padding removed.
REQ-012 SHALL have ports: out_valid output 1; out_keep output 8 (bit i marks byte i valid); out_eop output 1.
REQ-013 SHALL have ports: short_err output 1: one-cycle pulse when in_eop arrives before the true-data length is reached.

Function
REQ-014 SHALL register every output, giving exactly 1 cycle of latency from input word to output word; there is no backpressure.
REQ-015 SHALL implement the states IDLE, PASS, STRIP and DROP.
REQ-016 SHALL, in IDLE, on in_valid&in_sop: capture small_integer_cnt and small_bits_more; go to STRIP if len_strobe&small_frame, otherwise go to PASS; the sop word itself is processed under the new state.
REQ-017 SHALL, in PASS, forward every word with out_keep=8'hFF, out_eop=in_eop, and return to IDLE on in_eop.
REQ-018 SHALL, in STRIP, keep a 13-bit word index w that is 0 on the sop word and increments on each in_valid word.
REQ-019 SHALL, in STRIP, treat a word with w<cnt as a full word: out_keep=8'hFF, out_eop=1 only if (w==cnt-1 and bits==0).
REQ-020 SHALL, in STRIP, treat the word with w==cnt and bits!=0 as the final word: out_keep=(1<<bits)-1, out_eop=1.
REQ-021 SHALL, after the final word is emitted, suppress out_valid for the remaining pad words: enter DROP, or go to IDLE if that word has in_eop.
REQ-022 SHALL, in DROP, discard words and return to IDLE on in_valid&in_eop.
REQ-023 SHALL, for cnt==0 and bits==0, emit on the sop word a single output with out_keep=8'h00 and out_eop=1.
REQ-024 SHALL, in STRIP, on in_eop before the final word: emit that word with out_keep=8'hFF and out_eop=1, pulse short_err, and return to IDLE.
REQ-025 SHALL ignore in_sop outside IDLE; the frame in progress continues.
REQ-026 SHALL ignore cycles where in_valid=0: no state change, and out_valid=0 on the next cycle.
REQ-027 SHALL ignore out_data contents when out_valid=0; the verification bench does not check them.

Reset
REQ-028 SHALL, on reset, set state=IDLE, w=0, out_data=0, out_valid=0, out_keep=0, out_eop=0 and short_err=0, without waiting for a clock edge.
REQ-029 SHALL, when reset is asserted mid-frame, discard the frame and output nothing further from it; the next frame is accepted only on a new in_sop.

Configuration
REQ-030 SHALL, with RX_PAD_STRIP_STATS_EN defined, add output strip_cnt[15:0]: a saturating count of frames that went through STRIP, reset to 0, incremented on the cycle that frame's out_eop is emitted.
REQ-031 SHALL, without RX_PAD_STRIP_STATS_EN, omit the strip_cnt port and its counter entirely.

Verification
REQ-032 SHALL cover: 6-word frame, small_frame=0 -> 6 outputs, all keep FF, eop on word 5 only, 1 cycle of latency.
REQ-033 SHALL cover: small_frame=1, cnt=2, bits=3, 6-word frame -> 3 outputs with keep FF, FF, 07; eop on the third; words 3-5 dropped.
REQ-034 SHALL cover: small_frame=1, cnt=3, bits=0 -> eop with keep FF on word 2; words 3-5 dropped.
REQ-035 SHALL cover: small_frame=1, cnt=0, bits=0 -> one output with keep 00 and eop; all pad words dropped.
REQ-036 SHALL cover: small_frame=1, cnt=4, bits=2, in_eop on word 2 -> word 2 emitted with eop, short_err pulses once, state returns to IDLE.
REQ-037 SHALL cover: reset asserted on word 1 of a STRIP frame, then a back-to-back PASS frame -> no outputs from the first frame; the second frame is forwarded intact.
